// File: rtl/simple_risc_mem_pkg.sv
// Shared types and default widths for the simple RISC memory responder.
package simple_risc_mem_pkg;

    localparam int SR_ADDR_W = 8;
    localparam int SR_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One captured bus request; field widths follow the package defaults.
    typedef struct packed {
        logic                   we;
        logic [SR_ADDR_W-1:0]   addr;
        logic [SR_DATA_W-1:0]   wdata;
        logic [SR_DATA_W/8-1:0] be;
    } req_t;

endpackage

// File: rtl/simple_risc_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read-first output. No reset on the array or the output register.
module simple_risc_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  idx;

    // Callers only enable the RAM for in-range addresses, so the low bits suffice.
    assign idx = addr[IDX_W-1:0];

    // Byte-lane writes and registered read, both only when enabled.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/simple_risc_mem_responder.sv
// Bus-side memory responder: accepts one request, waits WAIT_CYCLES, commits
// the access to the RAM on entry to RESP, then holds the response until taken.
module simple_risc_mem_responder
    import simple_risc_mem_pkg::*;
#(
    parameter int ADDR_W      = SR_ADDR_W,
    parameter int DATA_W      = SR_DATA_W,
    parameter int DEPTH       = 2**ADDR_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    req_t              hold_q, hold_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_rd_q, rsp_rd_d;
    req_t              op;
    logic              commit;
    logic              in_range;
    logic              ram_en;
    logic [DATA_W/8-1:0] ram_be;
    logic [DATA_W-1:0] ram_rdata;

    // Operation being committed: live inputs when committing straight from IDLE.
    always_comb begin
        op = hold_q;
        if (state_q == ST_IDLE) begin
            op = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
        end
        in_range = (int'(op.addr) < DEPTH);
    end

    // Next-state, wait counter, capture and response flags.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        rsp_err_d = rsp_err_q;
        rsp_rd_d  = rsp_rd_q;
        commit    = 1'b0;
        req_ready = (state_q == ST_IDLE) && !rst;
        rsp_valid = (state_q == ST_RESP) && !rst;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    hold_d = op;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (commit) begin
            rsp_err_d = !in_range;
            rsp_rd_d  = !op.we && in_range;
        end
    end

    // State register; reset wins over any commit on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            rsp_err_q <= 1'b0;
            rsp_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            rsp_err_q <= rsp_err_d;
            rsp_rd_q  <= rsp_rd_d;
        end
    end

    assign ram_en = commit && in_range && !rst;
    assign ram_be = op.we ? op.be : '0;

    simple_risc_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_be),
        .addr  (op.addr),
        .wdata (op.wdata),
        .rdata (ram_rdata)
    );

    // Read data only surfaces for in-range reads; writes and errors return 0.
    assign rsp_rdata = rsp_rd_q ? ram_rdata : '0;
    assign rsp_err   = rsp_err_q;

endmodule
